shifter_arbiter: RTL

- Shares one combinational barrel_shifter (logical shift, zero fill; shift_dir 0 = left, 1 = right) between NREQ requesters.
- Each requester issues shift commands over a valid/ready handshake.
- A round-robin arbiter grants one command per cycle, applies it through the shifter and registers the result with requester id on a valid/ready output port.
- Sits between the command sources and the shared shifter datapath.

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/barrel_shifter.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/shifter_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the shifter_arbiter block.
// Optional per-requester grant counters are enabled by SHIFTER_ARB_GRANT_CNT_EN.
package shifter_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Round-robin pointer step: p+1 wrapping at n.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logical barrel shifter, zero fill; dir 0 = left, 1 = right.
module barrel_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic [N-1:0]  data,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  output logic [N-1:0]  result
);

  always_comb begin
    result = '0;
    if (dir == DIR_RIGHT) begin
      result = data >> amt;
    end else begin
      result = data << amt;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant and wraps.
module rr_arbiter
  import shifter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cur;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cur   = last;
    for (int k = 0; k < NREQ; k++) begin
      cur = IW'(ptr_inc(32'(cur), NREQ));
      if (enable && !found && req[cur]) begin
        found    = 1'b1;
        gnt[cur] = 1'b1;
        idx      = cur;
      end
    end
  end

endmodule

// File: rtl/shifter_arbiter.sv
// NREQ requesters share one barrel shifter through a round-robin arbiter and a result register.
// Define SHIFTER_ARB_GRANT_CNT_EN to add saturating per-requester grant counters (grant_cnt).
module shifter_arbiter
  import shifter_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 2,
  localparam int unsigned AW  = $clog2(N),
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*N-1:0]  req_data,
  input  logic [NREQ*AW-1:0] req_amt,
  input  logic [NREQ-1:0]    req_dir,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data,
  output logic [IW-1:0]      out_id
`ifdef SHIFTER_ARB_GRANT_CNT_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  state_e          state_q, state_d;
  logic [IW-1:0]   last_gnt;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            can_accept;
  logic            fire;
  logic [N-1:0]    sel_data;
  logic [AW-1:0]   sel_amt;
  logic            sel_dir;
  logic [N-1:0]    shifted;

  // Reset also blocks handshakes so nothing is accepted while rst_n is low.
  assign can_accept = rst_n && ((state_q == EMPTY) || out_ready);
  assign fire       = |gnt;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (req_valid),
    .enable (can_accept),
    .last   (last_gnt),
    .gnt    (gnt),
    .idx    (gnt_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_dir  = DIR_LEFT;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_data = req_data[i*N +: N];
        sel_amt  = req_amt[i*AW +: AW];
        sel_dir  = req_dir[i];
      end
    end
  end

  barrel_shifter #(
    .N (N)
  ) u_shift (
    .data   (sel_data),
    .amt    (sel_amt),
    .dir    (sel_dir),
    .result (shifted)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (fire) state_d = FULL;
      FULL:    if (out_ready) state_d = fire ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    req_ready = gnt;
    out_valid = (state_q == FULL);
  end

  // Result and pointer update only on an accepted command; they hold on drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_id   <= '0;
      last_gnt <= IW'(NREQ - 1);
    end else if (fire) begin
      out_data <= shifted;
      out_id   <= gnt_idx;
      last_gnt <= gnt_idx;
    end
  end

`ifdef SHIFTER_ARB_GRANT_CNT_EN
  logic [NREQ*CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
          cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
